// File: rtl/fm_reg_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fm_reg_write_sequencer
//  Description : Queued write controller for the FM/SSG sound core register
//                bus. Buffers (register, value) pairs in a FIFO and replays
//                each one as a timed two-phase bus write (address phase,
//                data phase) followed by a programmable settling gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module fm_reg_write_sequencer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int WAIT_CYCLES = 479,
    parameter int CNT_W       = 16
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_reg,
    input  logic [7:0]                    req_val,
    output logic                          cen,
    output logic                          cs_n,
    output logic                          wr_n,
    output logic                          addr,
    output logic [7:0]                    din,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          wr_done
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    // Bus sequencer states; outputs are registered with the state so the
    // bus always shows the values belonging to the state being entered.
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_A_SETUP = 4'd1,
        S_A_STB   = 4'd2,
        S_A_HOLD  = 4'd3,
        S_D_SETUP = 4'd4,
        S_D_STB   = 4'd5,
        S_D_HOLD  = 4'd6,
        S_WAIT    = 4'd7
    } state_t;

    // Request FIFO storage and bookkeeping
    logic [7:0]         r_mem_reg [FIFO_DEPTH];
    logic [7:0]         r_mem_val [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic [c_lvl_w-1:0] w_level_nxt;
    logic               r_req_ready;
    logic               w_push;
    logic               w_pop;

    // Sequencer state, current pair and settling counter
    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_cur_reg;
    logic [7:0]         r_cur_val;
    logic [7:0]         w_cur_reg_nxt;
    logic [7:0]         w_cur_val_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    // Registered bus outputs and their next values
    logic               r_wr_n;
    logic               r_addr;
    logic [7:0]         r_din;
    logic               r_wr_done;
    logic               r_busy;
    logic               w_wr_n_nxt;
    logic               w_addr_nxt;
    logic [7:0]         w_din_nxt;
    logic               w_wr_done_nxt;
    logic               w_busy_nxt;

    // A push is only taken against the registered not-full flag, so a push
    // while full is dropped even if the sequencer pops in the same cycle.
    assign w_push = req_valid & r_req_ready;

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_lvl_w'(1);
            2'b01:   w_level_nxt = r_level - c_lvl_w'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // FIFO storage write; contents need no reset since the level gates reads
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem_reg[r_wr_ptr] <= req_reg;
            r_mem_val[r_wr_ptr] <= req_val;
        end
    end

    // FIFO pointers, level and ready flag
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_req_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_level     <= w_level_nxt;
            r_req_ready <= (w_level_nxt != c_lvl_w'(FIFO_DEPTH));
        end
    end

    // Next-state and next-output decode for the two-phase bus write
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_cur_reg_nxt = r_cur_reg;
        w_cur_val_nxt = r_cur_val;
        w_cnt_nxt     = r_cnt;
        w_wr_n_nxt    = 1'b1;
        w_addr_nxt    = r_addr;
        w_din_nxt     = r_din;
        w_wr_done_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_addr_nxt = 1'b0;
                if (r_level != '0) begin
                    w_pop         = 1'b1;
                    w_cur_reg_nxt = r_mem_reg[r_rd_ptr];
                    w_cur_val_nxt = r_mem_val[r_rd_ptr];
                    w_din_nxt     = r_mem_reg[r_rd_ptr];
                    w_state_nxt   = S_A_SETUP;
                end
            end
            S_A_SETUP: begin
                w_addr_nxt  = 1'b0;
                w_din_nxt   = r_cur_reg;
                w_wr_n_nxt  = 1'b0;
                w_state_nxt = S_A_STB;
            end
            S_A_STB: begin
                w_addr_nxt  = 1'b0;
                w_din_nxt   = r_cur_reg;
                w_state_nxt = S_A_HOLD;
            end
            S_A_HOLD: begin
                // addr flips only here, with wr_n high on both sides
                w_addr_nxt  = 1'b1;
                w_din_nxt   = r_cur_val;
                w_state_nxt = S_D_SETUP;
            end
            S_D_SETUP: begin
                w_addr_nxt  = 1'b1;
                w_din_nxt   = r_cur_val;
                w_wr_n_nxt  = 1'b0;
                w_state_nxt = S_D_STB;
            end
            S_D_STB: begin
                w_addr_nxt    = 1'b1;
                w_din_nxt     = r_cur_val;
                w_wr_done_nxt = 1'b1;
                w_state_nxt   = S_D_HOLD;
            end
            S_D_HOLD: begin
                w_addr_nxt = 1'b0;
                if (WAIT_CYCLES == 0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_addr_nxt = 1'b0;
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_addr_nxt  = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE) || (w_level_nxt != '0);
    end

    // State, current pair, counter and bus output registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cur_reg <= '0;
            r_cur_val <= '0;
            r_cnt     <= '0;
            r_wr_n    <= 1'b1;
            r_addr    <= 1'b0;
            r_din     <= '0;
            r_wr_done <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_reg <= w_cur_reg_nxt;
            r_cur_val <= w_cur_val_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr_n    <= w_wr_n_nxt;
            r_addr    <= w_addr_nxt;
            r_din     <= w_din_nxt;
            r_wr_done <= w_wr_done_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign cen        = 1'b1;
    assign cs_n       = 1'b0;
    assign wr_n       = r_wr_n;
    assign addr       = r_addr;
    assign din        = r_din;
    assign busy       = r_busy;
    assign wr_done    = r_wr_done;
    assign fifo_level = r_level;
    assign req_ready  = r_req_ready;

endmodule
`default_nettype wire

// File: tb/tb_fm_reg_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fm_reg_write_sequencer
//  Description : Scoreboard bench for fm_reg_write_sequencer. Instance A uses
//                the default 479-cycle gap, instance B a zero gap. Expected
//                bus writes are queued at stimulus time and checked by a
//                monitor on every wr_n strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_reg_write_sequencer;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst;

    logic       a_valid, a_ready, a_cen, a_cs_n, a_wr_n, a_addr, a_busy, a_done;
    logic [7:0] a_reg, a_val, a_din;
    logic [3:0] a_level;
    logic       b_valid, b_ready, b_cen, b_cs_n, b_wr_n, b_addr, b_busy, b_done;
    logic [7:0] b_reg, b_val, b_din;
    logic [3:0] b_level;

    fm_reg_write_sequencer #(.FIFO_DEPTH(8), .WAIT_CYCLES(479), .CNT_W(16)) u_dut_a (
        .clk_in(clk_in), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_reg(a_reg), .req_val(a_val), .cen(a_cen), .cs_n(a_cs_n),
        .wr_n(a_wr_n), .addr(a_addr), .din(a_din), .busy(a_busy),
        .fifo_level(a_level), .wr_done(a_done)
    );

    fm_reg_write_sequencer #(.FIFO_DEPTH(8), .WAIT_CYCLES(0), .CNT_W(16)) u_dut_b (
        .clk_in(clk_in), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_reg(b_reg), .req_val(b_val), .cen(b_cen), .cs_n(b_cs_n),
        .wr_n(b_wr_n), .addr(b_addr), .din(b_din), .busy(b_busy),
        .fifo_level(b_level), .wr_done(b_done)
    );

    typedef struct packed {
        logic        addr;
        logic [7:0]  din;
        logic [15:0] gap;   // cycles since previous strobe; 0 = unchecked
    } exp_t;

    exp_t exp_q [2][$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   last_s [2];
    int   n_done [2];

    logic [1:0] m_wrn, m_addr, m_done;
    logic [1:0] m_prev_wrn = 2'b11;
    logic [7:0] m_din [2];
    assign m_wrn    = {b_wr_n, a_wr_n};
    assign m_addr   = {b_addr, a_addr};
    assign m_done   = {b_done, a_done};
    assign m_din[0] = a_din;
    assign m_din[1] = b_din;

    always @(posedge clk_in) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic exp_write(input int d, input logic [7:0] r, input logic [7:0] v,
                             input logic [15:0] gap_a);
        exp_q[d].push_back('{addr: 1'b0, din: r, gap: gap_a});
        exp_q[d].push_back('{addr: 1'b1, din: v, gap: 16'd3});
    endtask

    // Monitor: every wr_n strobe must match the head of the expected queue
    always @(negedge clk_in) begin : mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (m_done[d]) n_done[d]++;
            if (m_wrn[d] == 1'b0) begin
                chk($sformatf("dut%0d wr_n low twice", d), 32'(m_prev_wrn[d]), 32'd1);
                if (exp_q[d].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dut%0d unexpected write: got addr=%0d din=%02h, expected none",
                             d, m_addr[d], m_din[d]);
                end else begin
                    e = exp_q[d].pop_front();
                    chk($sformatf("dut%0d bus {addr,din}", d),
                        32'({m_addr[d], m_din[d]}), 32'({e.addr, e.din}));
                    if (e.gap != 0)
                        chk($sformatf("dut%0d strobe spacing", d), 32'(cyc - last_s[d]), 32'(e.gap));
                end
                last_s[d] = cyc;
            end
            m_prev_wrn[d] = m_wrn[d];
        end
    end

    task automatic wait_idle(input int d, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk_in);
            if (((d == 0) ? a_busy : b_busy) == 1'b0) break;
        end
        chk($sformatf("dut%0d idle within bound", d), 32'(i < bound), 32'd1);
    endtask

    // Single write on instance A; optionally queues two back-to-back pushes
    // late in its settling gap so both sit in the FIFO together.
    task automatic single_write(input logic [7:0] r, input logic [7:0] v, input bit b2b);
        a_valid = 1'b1; a_reg = r; a_val = v;
        exp_write(0, r, v, 16'd0);
        for (int k = 1; k <= 487; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                a_valid = 1'b0;
                chk("sw level T+1", 32'(a_level), 32'd1);
                chk("sw busy T+1", 32'(a_busy), 32'd1);
            end
            if (k == 2) chk("sw A_SETUP {wr_n,addr,din}", 32'({a_wr_n, a_addr, a_din}), 32'({1'b1, 1'b0, r}));
            if (k == 3) chk("sw A_STB {wr_n,addr,din}", 32'({a_wr_n, a_addr, a_din}), 32'({1'b0, 1'b0, r}));
            if (k == 4) chk("sw A_HOLD {wr_n,addr,din}", 32'({a_wr_n, a_addr, a_din}), 32'({1'b1, 1'b0, r}));
            if (k == 6) chk("sw D_STB {wr_n,addr,din}", 32'({a_wr_n, a_addr, a_din}), 32'({1'b0, 1'b1, v}));
            if (k == 7) chk("sw D_HOLD {wr_done,wr_n,addr}", 32'({a_done, a_wr_n, a_addr}), 32'b111);
            if (k == 8) chk("sw WAIT {wr_done,addr}", 32'({a_done, a_addr}), 32'b00);
            if (k == 486) chk("sw busy at T+486", 32'(a_busy), 32'd1);
            if (k == 487 && !b2b) chk("sw busy at T+487", 32'(a_busy), 32'd0);
            if (b2b) begin
                if (k == 485) begin
                    a_valid = 1'b1; a_reg = 8'hB0; a_val = 8'h07;
                    exp_write(0, 8'hB0, 8'h07, 16'd483);
                end
                if (k == 486) begin
                    chk("b2b level 1", 32'(a_level), 32'd1);
                    a_reg = 8'h30; a_val = 8'h01;
                    exp_write(0, 8'h30, 8'h01, 16'd483);
                end
                if (k == 487) begin
                    chk("b2b level 2", 32'(a_level), 32'd2);
                    a_valid = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_reg = '0; a_val = '0;
        b_valid = 1'b0; b_reg = '0; b_val = '0;
        last_s = '{0, 0};
        n_done = '{0, 0};
        repeat (4) @(negedge clk_in);
        chk("rst {cen,cs_n,wr_n,addr}", 32'({a_cen, a_cs_n, a_wr_n, a_addr}), 32'b1010);
        chk("rst din", 32'(a_din), 32'd0);
        chk("rst {busy,wr_done,ready}", 32'({a_busy, a_done, a_ready}), 32'b001);
        chk("rst level", 32'(a_level), 32'd0);
        chk("rst B {busy,ready,level}", 32'({b_busy, b_ready, b_level}), 32'({1'b0, 1'b1, 4'd0}));
        rst = 1'b0;
        @(negedge clk_in);

        // Single write followed by back-to-back pair
        single_write(8'h27, 8'h3B, 1'b1);
        wait_idle(0, 2000);

        // Full FIFO: 12 cycles of requests, 9 accepted
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("full ready i=%0d", i), 32'(a_ready), 32'(i <= 8));
            chk($sformatf("full level i=%0d", i), 32'(a_level),
                32'((i == 0) ? 0 : (i == 1) ? 1 : ((i - 1 > 8) ? 8 : i - 1)));
            a_valid = 1'b1; a_reg = 8'(8'h40 + i); a_val = 8'(8'h80 + i);
            if (i <= 8) exp_write(0, a_reg, a_val, (i == 0) ? 16'd0 : 16'd483);
            @(negedge clk_in);
        end
        a_valid = 1'b0;
        chk("full level after burst", 32'(a_level), 32'd8);
        wait_idle(0, 5000);

        // Simultaneous push and pop at level 3
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_reg = 8'(8'hA0 + i); a_val = 8'(8'hC0 + i);
            exp_write(0, a_reg, a_val, (i == 0) ? 16'd0 : 16'd483);
            @(negedge clk_in);
        end
        a_valid = 1'b0;
        chk("pp level c4", 32'(a_level), 32'd3);
        repeat (483) @(negedge clk_in);
        chk("pp level c487", 32'(a_level), 32'd3);
        chk("pp idle {wr_n,addr}", 32'({a_wr_n, a_addr}), 32'b10);
        a_valid = 1'b1; a_reg = 8'hA4; a_val = 8'hC4;
        exp_write(0, 8'hA4, 8'hC4, 16'd483);
        @(negedge clk_in);
        a_valid = 1'b0;
        chk("pp level c488", 32'(a_level), 32'd3);
        chk("pp A_SETUP din", 32'(a_din), 32'hA1);
        wait_idle(0, 3000);

        // Reset during the data strobe
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_reg = 8'(8'h11 + i); a_val = 8'(8'h22 + i);
            @(negedge clk_in);
        end
        a_valid = 1'b0;
        exp_write(0, 8'h11, 8'h22, 16'd0);
        repeat (3) @(negedge clk_in);
        chk("rmid D_STB {wr_n,addr,din}", 32'({a_wr_n, a_addr, a_din}), 32'({1'b0, 1'b1, 8'h22}));
        chk("rmid level before", 32'(a_level), 32'd2);
        rst = 1'b1;
        @(negedge clk_in);
        chk("rmid {wr_n,addr,din}", 32'({a_wr_n, a_addr, a_din}), 32'({1'b1, 1'b0, 8'h00}));
        chk("rmid {busy,wr_done,ready,level}", 32'({a_busy, a_done, a_ready, a_level}),
            32'({1'b0, 1'b0, 1'b1, 4'd0}));
        rst = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rmid stays idle", 32'(a_busy), 32'd0);
        single_write(8'h55, 8'hAA, 1'b0);

        // Pointer wrap on the zero-gap instance: 20 streamed writes
        begin
            int n = 0;
            for (int g = 0; g < 400 && n < 20; g++) begin
                b_valid = 1'b1; b_reg = 8'(n * 7 + 3); b_val = 8'(255 - n);
                if (b_ready) begin
                    exp_write(1, b_reg, b_val, (n == 0) ? 16'd0 : 16'd4);
                    n++;
                end
                @(negedge clk_in);
            end
            b_valid = 1'b0;
            chk("wrap pushes accepted", 32'(n), 32'd20);
        end
        wait_idle(1, 400);

        chk("A expected writes left", 32'(exp_q[0].size()), 32'd0);
        chk("B expected writes left", 32'(exp_q[1].size()), 32'd0);
        chk("A wr_done pulses", 32'(n_done[0]), 32'd18);
        chk("B wr_done pulses", 32'(n_done[1]), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fm_reg_write_sequencer.md
Name: fm_reg_write_sequencer

Overview:
- Queued write controller for the FM/SSG sound core's CPU-style register bus (cen, cs_n, wr_n, addr, din).
- Accepts (register, value) pairs over a valid/ready handshake and buffers them in an internal FIFO.
- Replays each pair as a timed two-phase bus write: address phase with addr=0, then data phase with addr=1, followed by a programmable settling gap.
- Replaces hard-coded counter-matched write schedules; any number of upstream init or patch loaders feed it.

Parameters:
- FIFO_DEPTH, 8, entries in request FIFO; power of two, at least 2.
- WAIT_CYCLES, 479, idle cycles inserted after each data phase before the next write may start; 0 is legal.
- CNT_W, 16, width of the wait counter; must satisfy WAIT_CYCLES < 2^CNT_W.

Ports:
- clk_in  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; equals !full, registered.
- req_reg  in  8  register address to write.
- req_val  in  8  register value.
- cen  out  1  clock enable to core; constant 1 out of reset.
- cs_n  out  1  chip select; constant 0.
- wr_n  out  1  write strobe, active low.
- addr  out  1  0 = address phase, 1 = data phase.
- din  out  8  bus data.
- busy  out  1  high whenever state != IDLE or FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- wr_done  out  1  one-cycle pulse on the D_HOLD cycle of each completed write.

Behaviour:
- Reset values (applied on the next edge with rst=1, from any state): cen=1, cs_n=0, wr_n=1, addr=0, din=0, busy=0, wr_done=0, fifo_level=0, req_ready=1, state=IDLE. The FIFO is flushed, the wait counter is cleared, and any in-flight write is abandoned with wr_n forced to 1.
- Handshake: a push occurs when req_valid && req_ready at an edge.
  - req_ready depends only on the registered level. A push while full is ignored even if a pop happens in the same cycle.
  - A simultaneous push and pop when not full leaves fifo_level unchanged.
- All bus outputs are registered and change on the same edge as the state register, so they show the values of the state being entered. Sequence:
  - IDLE: wr_n=1, addr=0, din held. If the FIFO is non-empty, pop the head into cur_reg/cur_val and go to A_SETUP.
  - A_SETUP: addr=0, din=cur_reg, wr_n=1. Go to A_STB.
  - A_STB: wr_n=0, lasting exactly 1 cycle. Go to A_HOLD.
  - A_HOLD: wr_n=1, din=cur_reg held. Go to D_SETUP.
  - D_SETUP: addr=1, din=cur_val, wr_n=1. Go to D_STB.
  - D_STB: wr_n=0, lasting exactly 1 cycle. Go to D_HOLD.
  - D_HOLD: wr_n=1, addr=1, wr_done=1. Load the counter with WAIT_CYCLES. Go to WAIT, or directly to IDLE if WAIT_CYCLES=0.
  - WAIT: addr returns to 0 on entry. Decrement the counter; when it reaches 1, go to IDLE.
- Latency: a push accepted at edge T gives IDLE-pop at T+1, A_SETUP at T+2, and the first wr_n low at T+3, assuming the block is idle and the FIFO was empty.
- Write period: 7 cycles plus WAIT_CYCLES from one A_SETUP to the next when the FIFO stays non-empty (IDLE 1, 6 bus states, WAIT_CYCLES).
- Ordering: strictly FIFO. Pointers wrap modulo FIFO_DEPTH; level is 0..FIFO_DEPTH inclusive.
- Pushes are accepted in every state, including during an active write.
- wr_n is never low in two consecutive cycles.
- addr changes only while wr_n=1.

Test Plan:
- Single write: reset 4 cycles, then push (0x27, 0x3B) while idle. Required: wr_n low exactly at T+3 with addr=0 and din=0x27; wr_n low again at T+6 with addr=1 and din=0x3B; wr_done pulses at T+7; busy stays high until T+7+WAIT_CYCLES.
- Back-to-back with WAIT_CYCLES=479: push (0xB0,0x07) and (0x30,0x01) in consecutive cycles. Required: fifo_level reaches 1 then 2; the second address strobe falls exactly 486 cycles after the first; the bus carries 0xB0, 0x07, 0x30, 0x01 in that order.
- Full FIFO with FIFO_DEPTH=8: hold req_valid for 12 cycles with incrementing registers while the first write is in progress. Required: req_ready drops when level=8; only 9 entries are accepted (1 popped plus 8 queued); no push is taken while full; all 9 are written in order.
- Pointer wrap: stream 20 writes with WAIT_CYCLES=0. Required: every (reg,val) pair appears in order and the 7-cycle period is maintained.
- Reset mid-operation: assert rst during D_STB. Required: next edge wr_n=1, addr=0, din=0, fifo_level=0, busy=0, no wr_done; after release, a new push behaves as in the single-write test.
- Simultaneous push and pop: FIFO at level 3 and IDLE pops while a push occurs. Required: level stays 3 and the pushed entry is written last.
